// File: rtl/ptr_fe_pkg.sv
// Shared definitions for the paper tape reader front-end feeder.
// Register addresses, STATUS/CTRL bit positions and issue FSM states.
package ptr_fe_pkg;

  localparam logic A_DATA = 1'b0;
  localparam logic A_CTRL = 1'b1;

  localparam int C_FLUSH = 0;
  localparam int C_IRQEN = 1;
  localparam int C_RUN   = 2;

  localparam int S_EMPTY   = 16;
  localparam int S_FULL    = 17;
  localparam int S_STARVED = 18;
  localparam int S_OVF     = 19;
  localparam int S_RUN     = 20;
  localparam int S_IRQEN   = 21;
  localparam int S_ARMED   = 22;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT
  } issue_st_t;

endpackage

// File: rtl/fe_fifo.sv
// Single-clock byte FIFO: push/pop/flush, head data, count, empty, full.
// Ports: clk, reset, push, pop, flush, din -> head, count, empty, full, drop.
module fe_fifo
  import ptr_fe_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               din,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULLCNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_pop;
  logic          do_push;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULLCNT);
  assign count = cnt;
  assign head  = mem[rp];

  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // is still accepted then.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push & ~flush) mem[wp] <= din;
  end

endmodule

// File: rtl/ptr_fe_feeder.sv
// Host-fed frame buffer answering each reader request with one frame.
// Ports: host Avalon slave (h_*), low-water h_irq, reader fe_data_rq/ptr_*.
module ptr_fe_feeder
  import ptr_fe_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LOWMARK = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        h_address,
  input  logic        h_write,
  input  logic [31:0] h_writedata,
  input  logic        h_read,
  output logic [31:0] h_readdata,
  output logic        h_irq,
  input  logic        fe_data_rq,
  output logic        ptr_write,
  output logic [31:0] ptr_writedata
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LOW = (AW+1)'(LOWMARK);

  issue_st_t   st;
  logic        run;
  logic        irqen;
  logic        starved;
  logic        ovf;
  logic        wr_data;
  logic        wr_ctrl;
  logic        flush;
  logic        pop;
  logic [7:0]  head;
  logic [AW:0] count;
  logic        empty;
  logic        full;
  logic        drop;
  logic        unused;

  assign unused  = ^h_writedata[31:8];
  assign wr_data = h_write & (h_address == A_DATA);
  assign wr_ctrl = h_write & (h_address == A_CTRL);
  assign flush   = wr_ctrl & h_writedata[C_FLUSH];
  assign pop     = (st == ST_SEND);

  fe_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data),
    .pop   (pop),
    .flush (flush),
    .din   (h_writedata[7:0]),
    .head  (head),
    .count (count),
    .empty (empty),
    .full  (full),
    .drop  (drop)
  );

  // Frame is latched on entry to SEND so a flush during SEND cannot
  // corrupt it; the FIFO pop happens at the end of SEND.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st            <= ST_IDLE;
      ptr_write     <= 1'b0;
      ptr_writedata <= '0;
    end else begin
      ptr_write     <= 1'b0;
      ptr_writedata <= '0;
      unique case (st)
        ST_IDLE: begin
          if (fe_data_rq & run & ~empty) begin
            st            <= ST_SEND;
            ptr_write     <= 1'b1;
            ptr_writedata <= {24'b0, head};
          end
        end
        ST_SEND: st <= ST_WAIT;
        ST_WAIT: if (!fe_data_rq) st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run     <= 1'b0;
      irqen   <= 1'b0;
      starved <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        irqen <= h_writedata[C_IRQEN];
        run   <= h_writedata[C_RUN];
      end
      if (flush) begin
        starved <= 1'b0;
        ovf     <= 1'b0;
      end else begin
        if (drop) ovf <= 1'b1;
        if ((st == ST_IDLE) & fe_data_rq & run & empty)
          starved <= 1'b1;
      end
    end
  end

  assign h_irq = irqen & run & (count <= LOW);

  always_comb begin
    h_readdata = '0;
    if (h_read) begin
      if (h_address == A_CTRL) begin
        h_readdata[C_IRQEN] = irqen;
        h_readdata[C_RUN]   = run;
      end else begin
        h_readdata[10:0]      = 11'(count);
        h_readdata[S_EMPTY]   = empty;
        h_readdata[S_FULL]    = full;
        h_readdata[S_STARVED] = starved;
        h_readdata[S_OVF]     = ovf;
        h_readdata[S_RUN]     = run;
        h_readdata[S_IRQEN]   = irqen;
        h_readdata[S_ARMED]   = (st == ST_IDLE);
      end
    end
  end

endmodule

// File: tb/tb_ptr_fe_feeder.sv
// Self-checking bench for ptr_fe_feeder against a queue-based model.
// Directed scenarios plus a randomized push/request phase.
module tb_ptr_fe_feeder;

  logic        clk = 0;
  logic        reset = 1;
  logic        h_address = 0;
  logic        h_write = 0;
  logic [31:0] h_writedata = 0;
  logic        h_read = 0;
  logic [31:0] h_readdata;
  logic        h_irq;
  logic        fe_data_rq = 0;
  logic        ptr_write;
  logic [31:0] ptr_writedata;

  int checks = 0;
  int errors = 0;

  byte unsigned mq[$];
  byte unsigned exp_q[$];
  byte unsigned obs_q[$];
  bit m_starved, m_ovf, m_run, m_irqen;
  bit prev_w = 0;

  ptr_fe_feeder dut (
    .clk           (clk),
    .reset         (reset),
    .h_address     (h_address),
    .h_write       (h_write),
    .h_writedata   (h_writedata),
    .h_read        (h_read),
    .h_readdata    (h_readdata),
    .h_irq         (h_irq),
    .fe_data_rq    (fe_data_rq),
    .ptr_write     (ptr_write),
    .ptr_writedata (ptr_writedata)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      assert (!(ptr_write && prev_w) &&
              (ptr_write || ptr_writedata == 0) &&
              ptr_writedata[31:8] == 0) else begin
        errors++;
        $error("FAIL strobe_shape observed=%b/%h prev=%b", ptr_write,
               ptr_writedata, prev_w);
      end
      if (ptr_write) obs_q.push_back(ptr_writedata[7:0]);
    end
    prev_w = ptr_write;
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_wr(bit a, logic [31:0] d);
    h_address = a;
    h_writedata = d;
    h_write = 1;
    step(1);
    h_write = 0;
    if (!a) begin
      if (mq.size() < 64) mq.push_back(d[7:0]);
      else m_ovf = 1;
    end else begin
      if (d[0]) begin
        mq.delete();
        m_starved = 0;
        m_ovf = 0;
      end
      m_irqen = d[1];
      m_run = d[2];
    end
  endtask

  function automatic logic [31:0] exp_status(bit armed);
    logic [31:0] v;
    v = '0;
    v[10:0] = 11'(mq.size());
    v[16] = (mq.size() == 0);
    v[17] = (mq.size() == 64);
    v[18] = m_starved;
    v[19] = m_ovf;
    v[20] = m_run;
    v[21] = m_irqen;
    v[22] = armed;
    return v;
  endfunction

  task automatic check_status(string tag, bit armed);
    logic [31:0] v;
    h_address = 0;
    h_read = 1;
    #1;
    v = h_readdata;
    h_read = 0;
    chk({tag, "_status"}, v, exp_status(armed));
    chk({tag, "_irq"}, 32'(h_irq),
        32'(m_irqen && m_run && mq.size() <= 16));
  endtask

  task automatic model_req();
    if (m_run && mq.size() > 0) exp_q.push_back(mq.pop_front());
    else if (m_run) m_starved = 1;
  endtask

  task automatic request(int hold);
    model_req();
    fe_data_rq = 1;
    step(hold);
    fe_data_rq = 0;
    step(3);
  endtask

  task automatic compare_issued(string tag);
    int n;
    chk({tag, "_nframes"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk({tag, "_frame"}, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] v;
    byte unsigned x;
    step(2);
    chk("rst_pw", 32'(ptr_write), 0);
    chk("rst_pwd", ptr_writedata, 0);
    chk("rst_irq", 32'(h_irq), 0);
    reset = 0;
    step(1);
    check_status("reset", 1);
    h_address = 1;
    h_read = 1;
    #1;
    v = h_readdata;
    h_read = 0;
    chk("reset_ctrl", v, 0);

    // three frames, three requests
    host_wr(1, 4);
    host_wr(0, 32'h81);
    host_wr(0, 32'h42);
    host_wr(0, 32'h3F);
    check_status("fill3", 1);
    repeat (3) request(2);
    compare_issued("order");
    check_status("drain3", 1);

    // long request gives exactly one frame, with one-cycle latency
    host_wr(0, 32'hA1);
    host_wr(0, 32'hB2);
    model_req();
    fe_data_rq = 1;
    step(1);
    chk("lat_pw", 32'(ptr_write), 1);
    chk("lat_pwd", ptr_writedata, 32'hA1);
    step(9);
    check_status("hold", 0);
    fe_data_rq = 0;
    step(3);
    compare_issued("hold");
    request(2);
    compare_issued("hold2");

    // underrun then data arrival
    model_req();
    fe_data_rq = 1;
    step(4);
    check_status("starve", 1);
    chk("starve_none", obs_q.size(), 0);
    host_wr(0, 32'h55);
    exp_q.push_back(mq.pop_front());
    chk("arr_n1", 32'(ptr_write), 0);
    step(1);
    chk("arr_pw", 32'(ptr_write), 1);
    chk("arr_pwd", ptr_writedata, 32'h55);
    fe_data_rq = 0;
    step(3);
    compare_issued("arrive");
    check_status("sticky", 1);
    host_wr(1, 5);
    check_status("flushed", 1);

    // overflow, then push and pop together while full
    for (int i = 0; i < 65; i++) host_wr(0, $urandom_range(0, 255));
    check_status("ovf", 1);
    model_req();
    fe_data_rq = 1;
    step(1);
    chk("pp_pw", 32'(ptr_write), 1);
    x = 8'($urandom_range(0, 255));
    h_address = 0;
    h_writedata = {24'b0, x};
    h_write = 1;
    fe_data_rq = 0;
    step(1);
    h_write = 0;
    mq.push_back(x);
    check_status("pushpop", 0);
    step(2);
    while (mq.size() > 0) request($urandom_range(1, 3));
    compare_issued("drain64");
    check_status("drained", 1);

    // low-water interrupt
    host_wr(1, 7);
    for (int i = 0; i < 20; i++) host_wr(0, $urandom_range(0, 255));
    check_status("irq20", 1);
    repeat (3) request(2);
    check_status("irq17", 1);
    request(2);
    check_status("irq16", 1);
    host_wr(1, 2);
    check_status("irq_norun", 1);
    request(2);
    compare_issued("irq");
    check_status("norun_req", 1);

    // randomized push/request mix
    host_wr(1, {29'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1});
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) != 0) host_wr(0, $urandom_range(0, 255));
      else request($urandom_range(1, 4));
    end
    compare_issued("rand");
    check_status("rand", 1);

    // reset while in WAIT
    host_wr(1, 7);
    for (int i = 0; i < 4; i++) host_wr(0, $urandom_range(0, 255));
    model_req();
    fe_data_rq = 1;
    step(2);
    chk("pre_rst_irq", 32'(h_irq), 1);
    reset = 1;
    #1;
    mq.delete();
    m_starved = 0;
    m_ovf = 0;
    m_run = 0;
    m_irqen = 0;
    chk("mid_rst_pw", 32'(ptr_write), 0);
    chk("mid_rst_pwd", ptr_writedata, 0);
    chk("mid_rst_irq", 32'(h_irq), 0);
    check_status("mid_rst", 1);
    fe_data_rq = 0;
    step(1);
    reset = 0;
    step(1);
    compare_issued("pre_rst");
    host_wr(1, 4);
    request(2);
    compare_issued("post_rst");
    check_status("post_rst", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
